// File: rtl/return_addr_stack_if.sv
// Return-address-stack port bundle.
// Purpose : groups the EX-stage resolution inputs and the predictor-facing
//           outputs of return_addr_stack into a single interface.
// Signals : CACHE_READY, CACHE_READY_DATA - stall qualifiers (both must be 1)
//           EX_PC, CALL, RETURN, FLUSH     - resolved instruction in EX
//           RETURN_ADDR, RETURN_VALID      - predicted return target
//           STACK_COUNT                    - occupied entries
//           OVERFLOW_COUNT, UNDERFLOW_COUNT - 32-bit statistics
// Modports: master drives EX info and observes outputs; slave is the stack.
interface return_addr_stack_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
);
  localparam int PTR_WIDTH = $clog2(STACK_DEPTH);

  logic                  CACHE_READY;
  logic                  CACHE_READY_DATA;
  logic [ADDR_WIDTH-1:0] EX_PC;
  logic                  CALL;
  logic                  RETURN;
  logic                  FLUSH;
  logic [ADDR_WIDTH-1:0] RETURN_ADDR;
  logic                  RETURN_VALID;
  logic [PTR_WIDTH:0]    STACK_COUNT;
  logic [31:0]           OVERFLOW_COUNT;
  logic [31:0]           UNDERFLOW_COUNT;

  modport master (
    output CACHE_READY, CACHE_READY_DATA, EX_PC, CALL, RETURN, FLUSH,
    input  RETURN_ADDR, RETURN_VALID, STACK_COUNT, OVERFLOW_COUNT, UNDERFLOW_COUNT
  );

  modport slave (
    input  CACHE_READY, CACHE_READY_DATA, EX_PC, CALL, RETURN, FLUSH,
    output RETURN_ADDR, RETURN_VALID, STACK_COUNT, OVERFLOW_COUNT, UNDERFLOW_COUNT
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack for the fetch-side branch predictor.
// Purpose : records link addresses (EX_PC+4) of calls resolved in EX and pops
//           them on resolved returns; the top entry is the predicted target.
//           Updates advance only when both caches are ready and the EX
//           instruction is not flushed, matching the predictor's timing.
// Ports   : CLK - rising-edge clock
//           RST - asynchronous active-high reset
//           ras - return_addr_stack_if.slave (see interface header)
// All outputs decode registered state only.
module return_addr_stack #(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  return_addr_stack_if.slave ras
);
  localparam int PTR_WIDTH = $clog2(STACK_DEPTH);
  localparam int CNT_W     = PTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [PTR_WIDTH-1:0]  top_q, top_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [31:0]           ovf_q, ovf_d;
  logic [31:0]           unf_q, unf_d;

  logic                  adv;
  logic [ADDR_WIDTH-1:0] link;
  logic [PTR_WIDTH-1:0]  top_inc;
  logic [PTR_WIDTH-1:0]  top_dec;

  assign adv     = ras.CACHE_READY & ras.CACHE_READY_DATA & ~ras.FLUSH;
  assign link    = ras.EX_PC + ADDR_WIDTH'(4);
  assign top_inc = top_q + PTR_WIDTH'(1);
  assign top_dec = top_q - PTR_WIDTH'(1);

  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (adv) begin
      unique case ({ras.CALL, ras.RETURN})
        2'b10: begin
          // Push: when full, the wrapped pointer lands on the oldest entry.
          top_d        = top_inc;
          mem_d[top_inc] = link;
          if (count_q != FULL) count_d = count_q + CNT_W'(1);
          else                 ovf_d   = ovf_q + 32'd1;
        end
        2'b01: begin
          if (count_q != '0) begin
            top_d   = top_dec;
            count_d = count_q - CNT_W'(1);
          end else begin
            unf_d = unf_q + 32'd1;
          end
        end
        2'b11: begin
          // Co-routine swap: replace the top entry in place.
          mem_d[top_q] = link;
          if (count_q == '0) count_d = CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q   <= '{default: '0};
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ras.RETURN_VALID    = (count_q != '0);
  assign ras.RETURN_ADDR     = ras.RETURN_VALID ? mem_q[top_q] : '0;
  assign ras.STACK_COUNT     = count_q;
  assign ras.OVERFLOW_COUNT  = ovf_q;
  assign ras.UNDERFLOW_COUNT = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed testbench for return_addr_stack with a queue-based scoreboard.
module tb_return_addr_stack;
  logic CLK;
  logic RST;

  return_addr_stack_if #(.ADDR_WIDTH(32), .STACK_DEPTH(8)) bus ();

  return_addr_stack #(.ADDR_WIDTH(32), .STACK_DEPTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .ras (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int S_ADDR = 0;
  localparam int S_VLD  = 1;
  localparam int S_CNT  = 2;
  localparam int S_OVF  = 3;
  localparam int S_UNF  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_ADDR:  return bus.RETURN_ADDR;
      S_VLD:   return 32'(bus.RETURN_VALID);
      S_CNT:   return 32'(bus.STACK_COUNT);
      S_OVF:   return bus.OVERFLOW_COUNT;
      default: return bus.UNDERFLOW_COUNT;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  // Expected top-of-stack view: address, valid and count together.
  task automatic expect_top(input string tag, input logic [31:0] a,
                            input logic v, input logic [31:0] c);
    expect_v({tag, "_addr"},  S_ADDR, a);
    expect_v({tag, "_valid"}, S_VLD,  32'(v));
    expect_v({tag, "_count"}, S_CNT,  c);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive one EX slot, clock it, then compare queued expectations.
  task automatic cyc(input logic call, input logic ret, input logic flush,
                     input logic cr, input logic crd, input logic [31:0] pc);
    bus.CALL             = call;
    bus.RETURN           = ret;
    bus.FLUSH            = flush;
    bus.CACHE_READY      = cr;
    bus.CACHE_READY_DATA = crd;
    bus.EX_PC            = pc;
    @(posedge CLK);
    #1;
    bus.CALL   = 1'b0;
    bus.RETURN = 1'b0;
    drain();
  endtask

  initial begin
    RST                  = 1'b1;
    bus.CALL             = 1'b0;
    bus.RETURN           = 1'b0;
    bus.FLUSH            = 1'b0;
    bus.CACHE_READY      = 1'b1;
    bus.CACHE_READY_DATA = 1'b1;
    bus.EX_PC            = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    expect_top("reset", 32'h0, 1'b0, 32'd0);
    expect_v("reset_ovf", S_OVF, 32'd0);
    expect_v("reset_unf", S_UNF, 32'd0);
    drain();
    RST = 1'b0;

    // Three pushes then three pops.
    expect_top("push1", 32'h104, 1'b1, 32'd1);
    cyc(1, 0, 0, 1, 1, 32'h100);
    expect_top("push2", 32'h204, 1'b1, 32'd2);
    cyc(1, 0, 0, 1, 1, 32'h200);
    expect_top("push3", 32'h304, 1'b1, 32'd3);
    cyc(1, 0, 0, 1, 1, 32'h300);
    expect_top("pop1", 32'h204, 1'b1, 32'd2);
    cyc(0, 1, 0, 1, 1, 32'h0);
    expect_top("pop2", 32'h104, 1'b1, 32'd1);
    cyc(0, 1, 0, 1, 1, 32'h0);
    expect_top("pop3", 32'h0, 1'b0, 32'd0);
    cyc(0, 1, 0, 1, 1, 32'h0);

    // Nine pushes into an 8-deep stack: oldest entry is overwritten.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 1, 32'h1000 + 32'(16 * i));
    expect_top("ovf_push", 32'h1084, 1'b1, 32'd8);
    expect_v("ovf_cnt", S_OVF, 32'd1);
    cyc(1, 0, 0, 1, 1, 32'h1080);
    for (int k = 1; k <= 7; k++) begin
      expect_top($sformatf("ovf_pop%0d", k), 32'h1004 + 32'(16 * (8 - k)), 1'b1, 32'(8 - k));
      cyc(0, 1, 0, 1, 1, 32'h0);
    end
    expect_top("ovf_pop8", 32'h0, 1'b0, 32'd0);
    expect_v("ovf_unf0", S_UNF, 32'd0);
    cyc(0, 1, 0, 1, 1, 32'h0);

    // Underflow, then swap on empty.
    expect_top("underflow", 32'h0, 1'b0, 32'd0);
    expect_v("unf_cnt", S_UNF, 32'd1);
    cyc(0, 1, 0, 1, 1, 32'h0);
    expect_top("swap_empty", 32'h44, 1'b1, 32'd1);
    expect_v("swap_empty_unf", S_UNF, 32'd1);
    cyc(1, 1, 0, 1, 1, 32'h40);

    // Rebuild a stack holding only 0x504, then swap.
    expect_top("pop_to_empty", 32'h0, 1'b0, 32'd0);
    cyc(0, 1, 0, 1, 1, 32'h0);
    expect_top("push_500", 32'h504, 1'b1, 32'd1);
    cyc(1, 0, 0, 1, 1, 32'h500);
    expect_top("swap_full", 32'h604, 1'b1, 32'd1);
    expect_v("swap_ovf", S_OVF, 32'd1);
    expect_v("swap_unf", S_UNF, 32'd1);
    cyc(1, 1, 0, 1, 1, 32'h600);

    // Stalled push held for three cycles, released once.
    for (int s = 0; s < 3; s++) begin
      expect_top($sformatf("stall%0d", s), 32'h604, 1'b1, 32'd1);
      cyc(1, 0, 0, 1, 0, 32'h700);
    end
    expect_top("icache_stall", 32'h604, 1'b1, 32'd1);
    cyc(1, 0, 0, 0, 1, 32'h700);
    expect_top("stall_release", 32'h704, 1'b1, 32'd2);
    cyc(1, 0, 0, 1, 1, 32'h700);

    // Flushed push and flushed pops have no effect.
    expect_top("flush_push", 32'h704, 1'b1, 32'd2);
    cyc(1, 0, 1, 1, 1, 32'h800);
    expect_top("flush_pop", 32'h704, 1'b1, 32'd2);
    expect_v("flush_pop_unf", S_UNF, 32'd1);
    cyc(0, 1, 1, 1, 1, 32'h0);

    // Fill to five, then asynchronous reset between edges.
    cyc(1, 0, 0, 1, 1, 32'h900);
    cyc(1, 0, 0, 1, 1, 32'hA00);
    expect_top("count5", 32'hB04, 1'b1, 32'd5);
    cyc(1, 0, 0, 1, 1, 32'hB00);
    #1;
    RST = 1'b1;
    #1;
    expect_top("async_rst", 32'h0, 1'b0, 32'd0);
    expect_v("async_rst_ovf", S_OVF, 32'd0);
    expect_v("async_rst_unf", S_UNF, 32'd0);
    drain();
    #1;
    RST = 1'b0;
    expect_top("post_rst_push", 32'h7004, 1'b1, 32'd1);
    cyc(1, 0, 0, 1, 1, 32'h7000);
    expect_top("wrap_link", 32'h0, 1'b1, 32'd2);
    cyc(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    expect_top("pop_wrap", 32'h7004, 1'b1, 32'd1);
    cyc(0, 1, 0, 1, 1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Circular return-address stack (RAS) supplying the fetch-side predictor's `RETURN_ADDR` input. It records link addresses of calls resolved in the EX stage and pops them on resolved returns. It presents the current top-of-stack as the predicted return target with a validity flag. It shares the predictor's stall qualification (`CACHE_READY & CACHE_READY_DATA`) and update timing, so both structures advance on the same cycles.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, width of PCs and return addresses.
- `STACK_DEPTH`, 8, number of entries; power of two, ≥ 2.
- `PTR_WIDTH`, log2(`STACK_DEPTH`), localparam; width of the top pointer.

Ports:
- `CLK`  input  1  sole clock, rising edge.
- `RST`  input  1  asynchronous, active-high reset.
- `CACHE_READY`  input  1  instruction-cache ready; gates all updates.
- `CACHE_READY_DATA`  input  1  data-cache ready; gates all updates.
- `EX_PC`  input  `ADDR_WIDTH`  PC of the instruction in EX.
- `CALL`  input  1  EX instruction is a call (JAL/JALR with rd = x1/x5).
- `RETURN`  input  1  EX instruction is a return (JALR rs1 = x1/x5, rd ≠ link).
- `FLUSH`  input  1  EX instruction is squashed; suppresses push/pop.
- `RETURN_ADDR`  output  `ADDR_WIDTH`  top-of-stack entry; 0 when empty.
- `RETURN_VALID`  output  1  stack non-empty.
- `STACK_COUNT`  output  `PTR_WIDTH`+1  occupied entries, 0..`STACK_DEPTH`.
- `OVERFLOW_COUNT`  output  32  pushes that overwrote the oldest entry.
- `UNDERFLOW_COUNT`  output  32  pops issued while empty.

## Operation

- `adv = CACHE_READY & CACHE_READY_DATA & !FLUSH`. When `adv` = 0, no state changes.
- `link = EX_PC + 4`, truncated modulo 2^`ADDR_WIDTH` (0xFFFFFFFC → 0x00000000).
- State: `mem[0..STACK_DEPTH-1]`, `top` (`PTR_WIDTH` bits), `count` (`PTR_WIDTH`+1 bits), two 32-bit statistic counters.
- Push only (`adv & CALL & !RETURN`):
  - `top <= top+1` (wraps modulo `STACK_DEPTH`); `mem[top+1] <= link`.
  - If `count < STACK_DEPTH`, then `count <= count+1`.
  - Otherwise `count` holds, the oldest entry is silently overwritten, and `OVERFLOW_COUNT` increments.
- Pop only (`adv & RETURN & !CALL`):
  - If `count > 0`: `top <= top-1` (wraps), `count <= count-1`. Memory is untouched.
  - If `count == 0`: `top` and `count` hold, and `UNDERFLOW_COUNT` increments.
- Push and pop together (`adv & CALL & RETURN`, co-routine swap): `mem[top] <= link`, and `top` holds.
  - If `count == 0`, then `count <= 1`; otherwise `count` holds.
  - Neither statistic counter changes.
- Neither asserted: no change.
- Outputs:
  - `RETURN_VALID = (count != 0)`.
  - `RETURN_ADDR = RETURN_VALID ? mem[top] : 0`.
  - `STACK_COUNT = count`.
  - All outputs are combinational from registered state only; there is no combinational path from any input.
- Statistic counters wrap at 2^32.

## Timing

- All updates occur on the rising `CLK` edge; outputs reflect an update in the cycle after the qualifying edge (1-cycle latency).
- Reset (asynchronous, any time, including mid-push):
  - `top=0`, `count=0`, all `mem` entries = 0, both counters = 0.
  - Hence `RETURN_ADDR=0`, `RETURN_VALID=0`, `STACK_COUNT=0`, `OVERFLOW_COUNT=0`, `UNDERFLOW_COUNT=0` immediately on `RST` assertion.
  - The first update is possible on the first rising edge with `RST` low.
- Stall: a `CALL`/`RETURN` held across stalled cycles causes exactly one update, on the edge where `adv` = 1. The upstream stage holds EX stable during stalls.
- `FLUSH` is sampled on the same edge as `CALL`/`RETURN`. A flushed call or return has no effect, including on the counters.
- There is no speculative checkpointing: only EX-resolved, unflushed instructions update the stack.

## Test plan

- Reset, then push `EX_PC`=0x100, 0x200, 0x300 on consecutive ready cycles → after the 3rd edge, `RETURN_ADDR`=0x304 and `STACK_COUNT`=3. Three pops then yield 0x204, 0x104, 0 with `RETURN_VALID`=0.
- `STACK_DEPTH`=8: nine pushes of `EX_PC`=0x1000+16·i (i=0..8) → `STACK_COUNT`=8, `OVERFLOW_COUNT`=1, `RETURN_ADDR`=0x1084. Eight pops return 0x1074 down to 0x1014; the entry for 0x1004 is lost.
- Pop on empty stack → `UNDERFLOW_COUNT`=1, `STACK_COUNT`=0, `RETURN_ADDR`=0. Simultaneous `CALL`+`RETURN` on empty with `EX_PC`=0x40 → `STACK_COUNT`=1, `RETURN_ADDR`=0x44.
- Stack holding 0x504: `CALL`+`RETURN` with `EX_PC`=0x600 → `RETURN_ADDR`=0x604, `STACK_COUNT` unchanged.
- Push with `CACHE_READY_DATA`=0 for 3 cycles, then 1 → a single push. Push with `FLUSH`=1 → no change.
- Assert `RST` asynchronously between edges with `STACK_COUNT`=5 → all outputs 0 before the next edge. A push after release lands correctly with `STACK_COUNT`=1. `EX_PC`=0xFFFFFFFC push → `RETURN_ADDR`=0, `RETURN_VALID`=1.
